// File: rtl/cxd2545_soct_reader_if.sv
// cxd2545_soct_reader_if: start/status handshake and SOCT serial pins between host and status reader
interface cxd2545_soct_reader_if;
  logic       start;
  logic       busy;
  logic       valid;
  logic       xlat;
  logic       sqck;
  logic       soct_in;
  logic [7:0] per;
  logic [2:0] c1;
  logic [2:0] c2;
  logic       fok;
  logic       gfs;
  logic       lock;
  logic       emph;
  modport master (output start, soct_in, input busy, valid, xlat, sqck, per, c1, c2, fok, gfs, lock, emph);
  modport slave  (input start, soct_in, output busy, valid, xlat, sqck, per, c1, c2, fok, gfs, lock, emph);
endinterface

// File: rtl/cxd2545_soct_reader.sv
// cxd2545_soct_reader: latches the DSP status with xlat, clocks 18 SOCT bits out with sqck and presents them as parallel fields
module cxd2545_soct_reader #(
  parameter int DIV      = 4,
  parameter int XLAT_CYC = 4
) (
  input logic                    sclk,
  input logic                    rst,
  cxd2545_soct_reader_if.slave   bus
);
  localparam int HCMAX = DIV > XLAT_CYC ? DIV : XLAT_CYC;
  localparam int HW    = $clog2(HCMAX);
  localparam logic [HW-1:0] DIV_M1 = HW'(DIV - 1);
  localparam logic [HW-1:0] XL_M1  = HW'(XLAT_CYC - 1);
  typedef enum logic [2:0] {IDLE, LATCH, SETTLE, LOW, HIGH} state_t;
  state_t          state_q, state_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [4:0]      bc_q, bc_d;
  logic [16:0]     sr_q, sr_d;
  logic [17:0]     frame_q, frame_d;
  logic [1:0]      sync_q;
  logic            valid_q, valid_d, busy_q, busy_d, xlat_q, xlat_d, sqck_q, sqck_d;
  logic            s_soct, last;
  assign s_soct = sync_q[1];
  assign last   = hc_q == (state_q == LATCH ? XL_M1 : DIV_M1);
  always_comb begin
    state_d = state_q;
    hc_d    = (last || state_q == IDLE) ? '0 : hc_q + 1'b1;
    bc_d    = bc_q;
    sr_d    = sr_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE:   state_d = bus.start ? LATCH : IDLE;
      LATCH:  state_d = last ? SETTLE : LATCH;
      SETTLE: if (last) begin
        sr_d    = {s_soct, sr_q[16:1]};
        bc_d    = 5'd1;
        state_d = LOW;
      end
      LOW:    state_d = last ? HIGH : LOW;
      HIGH:   if (last) begin
        if (bc_q == 5'd17) begin
          frame_d = {s_soct, sr_q};
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          sr_d    = {s_soct, sr_q[16:1]};
          bc_d    = bc_q + 5'd1;
          state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    xlat_d = state_d != LATCH;
    sqck_d = state_d != LOW;
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      hc_q    <= '0;
      bc_q    <= '0;
      sr_q    <= '0;
      frame_q <= '0;
      sync_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      xlat_q  <= 1'b1;
      sqck_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bc_q    <= bc_d;
      sr_q    <= sr_d;
      frame_q <= frame_d;
      sync_q  <= {sync_q[0], bus.soct_in};
      valid_q <= valid_d;
      busy_q  <= busy_d;
      xlat_q  <= xlat_d;
      sqck_q  <= sqck_d;
    end
  end
  // frame_q[i] is the i-th bit received; C1/C2 arrive MSB first
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.xlat  = xlat_q;
  assign bus.sqck  = sqck_q;
  assign bus.per   = frame_q[7:0];
  assign bus.c1    = {frame_q[8], frame_q[9], frame_q[10]};
  assign bus.c2    = {frame_q[11], frame_q[12], frame_q[13]};
  assign bus.fok   = frame_q[14];
  assign bus.gfs   = frame_q[15];
  assign bus.lock  = frame_q[16];
  assign bus.emph  = frame_q[17];
endmodule

// File: tb/tb_cxd2545_soct_reader.sv
// tb_cxd2545_soct_reader: SOCT serializer model driving the reader; checks fields, strobes and waveform shape
module tb_cxd2545_soct_reader;
  typedef struct packed {
    logic [7:0] per;
    logic [2:0] c1;
    logic [2:0] c2;
    logic       fok;
    logic       gfs;
    logic       lock;
    logic       emph;
  } fields_t;
  typedef struct {
    logic [17:0] stream;
    fields_t     exp;
    string       name;
  } vec_t;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  cxd2545_soct_reader_if bus();
  cxd2545_soct_reader #(.DIV(4), .XLAT_CYC(4)) dut (.sclk(sclk), .rst(rst), .bus(bus));

  int n_vec = 0, n_err = 0;
  int cyc = 0, busy_cnt = 0, xl_cnt = 0, fall_cnt = 0, valid_cnt = 0, ovl_cnt = 0;
  logic prev_sq = 1'b1;
  logic [17:0] tx = '0, sreg = '0;
  int sidx = 0;
  logic px = 1'b1, ps = 1'b1;

  // serializer: loads on xlat fall presenting bit 0, next bit after each sqck fall, one cycle late
  always @(posedge sclk) begin
    if (rst) bus.soct_in <= 1'b0;
    else if (px === 1'b1 && bus.xlat === 1'b0) begin
      sreg = tx;
      sidx = 0;
      bus.soct_in <= tx[0];
    end else if (ps === 1'b1 && bus.sqck === 1'b0 && sidx < 17) begin
      sidx++;
      bus.soct_in <= sreg[sidx];
    end
    px = bus.xlat;
    ps = bus.sqck;
  end

  always @(posedge sclk) begin
    cyc++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.xlat === 1'b0) xl_cnt++;
    if (prev_sq === 1'b1 && bus.sqck === 1'b0) fall_cnt++;
    if (bus.valid === 1'b1) valid_cnt++;
    if (bus.xlat === 1'b0 && bus.sqck === 1'b0) ovl_cnt++;
    prev_sq = bus.sqck;
  end

  function automatic fields_t decode(input logic [17:0] s);
    logic q[$];
    fields_t f;
    for (int i = 0; i < 18; i++) q.push_back(s[i]);
    for (int i = 0; i < 8; i++) f.per[i] = q.pop_front();
    for (int i = 2; i >= 0; i--) f.c1[i] = q.pop_front();
    for (int i = 2; i >= 0; i--) f.c2[i] = q.pop_front();
    f.fok  = q.pop_front();
    f.gfs  = q.pop_front();
    f.lock = q.pop_front();
    f.emph = q.pop_front();
    return f;
  endfunction

  function automatic fields_t dut_fields();
    return {bus.per, bus.c1, bus.c2, bus.fok, bus.gfs, bus.lock, bus.emph};
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sclk);
      if (bus.valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_valid_timeout: got no strobe expected one within 400 cycles", name);
    end
  endtask

  task automatic frame(input logic [17:0] s, input fields_t e, input string name);
    int b0, x0, f0, o0, v0;
    bit ok;
    tx = s;
    b0 = busy_cnt; x0 = xl_cnt; f0 = fall_cnt; o0 = ovl_cnt; v0 = valid_cnt;
    bus.start = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0;
    chk({name, "_busy_rise"}, bus.busy, 1);
    wait_valid(name, ok);
    if (ok) begin
      chk({name, "_fields"}, dut_fields(), e);
      chk({name, "_busy_len"}, busy_cnt - b0, 144);
      chk({name, "_xlat_low"}, xl_cnt - x0, 4);
      chk({name, "_sqck_falls"}, fall_cnt - f0, 17);
      chk({name, "_overlap"}, ovl_cnt - o0, 0);
      chk({name, "_idle_lvls"}, {bus.xlat, bus.sqck, bus.busy}, 3'b110);
      @(negedge sclk);
      chk({name, "_valid_1cyc"}, bus.valid, 0);
      chk({name, "_hold"}, dut_fields(), e);
      chk({name, "_valid_cnt"}, valid_cnt - v0, 1);
    end
  endtask

  initial begin
    vec_t tbl[13];
    logic [17:0] hs[3];
    logic [17:0] r;
    int b0, v0, f0;
    int t[3];
    bit ok, all_ok;
    tbl[0]  = '{18'h155A5, {8'hA5, 3'b101, 3'b010, 4'b1010}, "a5"};
    tbl[1]  = '{18'h00001, {8'h01, 3'b000, 3'b000, 4'b0000}, "bit0"};
    tbl[2]  = '{18'h00080, {8'h80, 3'b000, 3'b000, 4'b0000}, "bit7"};
    tbl[3]  = '{18'h00100, {8'h00, 3'b100, 3'b000, 4'b0000}, "bit8"};
    tbl[4]  = '{18'h00400, {8'h00, 3'b001, 3'b000, 4'b0000}, "bit10"};
    tbl[5]  = '{18'h00800, {8'h00, 3'b000, 3'b100, 4'b0000}, "bit11"};
    tbl[6]  = '{18'h02000, {8'h00, 3'b000, 3'b001, 4'b0000}, "bit13"};
    tbl[7]  = '{18'h04000, {8'h00, 3'b000, 3'b000, 4'b1000}, "fok"};
    tbl[8]  = '{18'h08000, {8'h00, 3'b000, 3'b000, 4'b0100}, "gfs"};
    tbl[9]  = '{18'h10000, {8'h00, 3'b000, 3'b000, 4'b0010}, "lock"};
    tbl[10] = '{18'h20000, {8'h00, 3'b000, 3'b000, 4'b0001}, "emph"};
    tbl[11] = '{18'h3FFFF, {8'hFF, 3'b111, 3'b111, 4'b1111}, "ones"};
    tbl[12] = '{18'h00000, {8'h00, 3'b000, 3'b000, 4'b0000}, "zeros"};
    hs[0] = 18'h00001; hs[1] = 18'h00080; hs[2] = 18'h000FF;
    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    chk("reset_lvls", {bus.xlat, bus.sqck, bus.busy, bus.valid}, 4'b1100);
    chk("reset_fields", dut_fields(), 0);
    rst = 1'b0;
    repeat (3) @(negedge sclk);
    chk("idle_lvls", {bus.xlat, bus.sqck, bus.busy}, 3'b110);

    for (int i = 0; i < 13; i++) frame(tbl[i].stream, tbl[i].exp, tbl[i].name);

    for (int i = 0; i < 6; i++) begin
      r = 18'($urandom);
      frame(r, decode(r), "rand");
    end

    // start held: back-to-back frames with the status changing between them
    all_ok = 1'b1;
    tx = hs[0];
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid("held", ok);
      if (!ok) begin
        all_ok = 1'b0;
        break;
      end
      chk("held_fields", dut_fields(), decode(hs[k]));
      t[k] = cyc;
      if (k < 2) tx = hs[k + 1];
      else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (all_ok) begin
      chk("held_gap01", t[1] - t[0], 145);
      chk("held_gap12", t[2] - t[1], 145);
    end
    repeat (3) @(negedge sclk);
    chk("held_stopped", bus.busy, 0);

    // start pulses during a busy frame are dropped
    b0 = busy_cnt; v0 = valid_cnt;
    tx = 18'h2B3C5;
    bus.start = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0;
    repeat (9) @(negedge sclk);
    bus.start = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0;
    repeat (39) @(negedge sclk);
    bus.start = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0;
    wait_valid("ign", ok);
    if (ok) begin
      chk("ign_fields", dut_fields(), decode(18'h2B3C5));
      chk("ign_busy_len", busy_cnt - b0, 144);
    end
    repeat (300) @(negedge sclk);
    chk("ign_one_valid", valid_cnt - v0, 1);
    chk("ign_no_queue", busy_cnt - b0, 144);

    // reset in the middle of a frame
    frame(18'h0003C, decode(18'h0003C), "pre3c");
    chk("pre3c_per", bus.per, 8'h3C);
    tx = 18'h1D2B7;
    f0 = fall_cnt; v0 = valid_cnt;
    bus.start = 1'b1;
    @(negedge sclk);
    bus.start = 1'b0;
    for (int i = 0; i < 400 && fall_cnt - f0 < 9; i++) @(negedge sclk);
    chk("rst_bit9_reached", fall_cnt - f0, 9);
    rst = 1'b1;
    @(negedge sclk);
    chk("rst_mid_lvls", {bus.xlat, bus.sqck, bus.busy, bus.valid}, 4'b1100);
    chk("rst_mid_fields", dut_fields(), 0);
    rst = 1'b0;
    repeat (200) @(negedge sclk);
    chk("rst_no_valid", valid_cnt - v0, 0);
    chk("rst_idle", bus.busy, 0);
    frame(18'h1D2B7, decode(18'h1D2B7), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end within 50000 cycles");
    $fatal(1, "watchdog");
  end
endmodule
